// File: rtl/dcache_axi_master.sv
// AXI4 master for the data cache: line/word refills become AR/R bursts, dirty
// lines become 8-beat AW/W/B writebacks. Read and write channels run independently.
module dcache_axi_master #(
    parameter int ID_W  = 4,
    parameter int RD_ID = 1,
    parameter int WR_ID = 1
) (
    input  logic              clk,
    input  logic              reset,
    // cache read side
    input  logic              rd_req,
    input  logic [2:0]        rd_type,
    input  logic [31:0]       rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic [255:0]      ret_data,
    // cache writeback side
    input  logic              wr_req,
    input  logic [31:0]       wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [255:0]      wr_data,
    output logic              wr_rdy,
    // AR
    output logic [ID_W-1:0]   arid,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    // R
    input  logic [ID_W-1:0]   rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AW
    output logic [ID_W-1:0]   awid,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    // W
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // B
    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

    r_state_t         r_state;
    w_state_t         w_state;
    logic [7:0][31:0] rbuf;
    logic [3:0]       rcnt;
    logic [7:0][31:0] wbuf;
    logic [2:0]       wcnt;
    logic [26:0]      w_line;

    logic             w_accept;
    logic             w_busy_nxt;
    logic [26:0]      w_line_nxt;
    logic [26:0]      r_line_nxt;
    logic             hazard_nxt;

    logic             unused;
    assign unused = ^{rid, rresp, bid, bresp, wr_addr[4:0]};

    // Hazard is evaluated against next-cycle write state so that a write
    // accepted in the same cycle as a same-line read already blocks the AR.
    assign w_accept   = (w_state == W_IDLE) && wr_req;
    assign w_busy_nxt = w_accept ||
                        ((w_state != W_IDLE) && !((w_state == W_RESP) && bvalid));
    assign w_line_nxt = w_accept ? wr_addr[31:5] : w_line;
    assign r_line_nxt = (r_state == R_IDLE) ? rd_addr[31:5] : araddr[31:5];
    assign hazard_nxt = w_busy_nxt && (w_line_nxt == r_line_nxt);

    assign arid     = ID_W'(RD_ID);
    assign arburst  = 2'b01;
    assign ret_data = rbuf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= R_IDLE;
            rd_rdy    <= 1'b1;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ret_valid <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
            rbuf      <= '0;
            rcnt      <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_req) begin
                        rd_rdy  <= 1'b0;
                        rbuf    <= '0;
                        rcnt    <= '0;
                        arvalid <= !hazard_nxt;
                        r_state <= R_AR;
                        case (rd_type)
                            3'b100: begin
                                araddr <= {rd_addr[31:5], 5'b0};
                                arlen  <= 8'd7;
                                arsize <= 3'd2;
                            end
                            3'b000: begin
                                araddr <= rd_addr;
                                arlen  <= 8'd0;
                                arsize <= 3'd0;
                            end
                            3'b001: begin
                                araddr <= rd_addr;
                                arlen  <= 8'd0;
                                arsize <= 3'd1;
                            end
                            default: begin
                                araddr <= rd_addr;
                                arlen  <= 8'd0;
                                arsize <= 3'd2;
                            end
                        endcase
                    end
                end
                R_AR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= R_DATA;
                    end else if (!arvalid) begin
                        arvalid <= !hazard_nxt;
                    end
                end
                R_DATA: begin
                    if (rvalid) begin
                        // rcnt saturates at 8 so surplus beats are discarded
                        if (!rcnt[3]) begin
                            rbuf[rcnt[2:0]] <= rdata;
                            rcnt            <= rcnt + 4'd1;
                        end
                        if (rlast) begin
                            rready    <= 1'b0;
                            ret_valid <= 1'b1;
                            r_state   <= R_RET;
                        end
                    end
                end
                R_RET: begin
                    ret_valid <= 1'b0;
                    rd_rdy    <= 1'b1;
                    r_state   <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign awid    = ID_W'(WR_ID);
    assign awaddr  = {w_line, 5'b0};
    assign awlen   = 8'd7;
    assign awsize  = 3'd2;
    assign awburst = 2'b01;
    assign wdata   = wbuf[wcnt];
    assign wlast   = (w_state == W_DATA) && (wcnt == 3'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state <= W_IDLE;
            wr_rdy  <= 1'b1;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            w_line  <= '0;
            wstrb   <= '0;
            wbuf    <= '0;
            wcnt    <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_req) begin
                        wr_rdy  <= 1'b0;
                        w_line  <= wr_addr[31:5];
                        wstrb   <= wr_wstrb;
                        wbuf    <= wr_data;
                        wcnt    <= '0;
                        awvalid <= 1'b1;
                        w_state <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wready) begin
                        if (wcnt == 3'd7) begin
                            wvalid  <= 1'b0;
                            bready  <= 1'b1;
                            w_state <= W_RESP;
                        end else begin
                            wcnt <= wcnt + 3'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        wr_rdy  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_axi_master.sv
// Bench for dcache_axi_master: table of read requests, writeback and hazard
// sequences, reset abort; R and W data checked through expectation queues.
module tb_dcache_axi_master;

    localparam int ID_W = 4;

    logic            clk, reset;
    logic            rd_req, rd_rdy, ret_valid;
    logic [2:0]      rd_type;
    logic [31:0]     rd_addr;
    logic [255:0]    ret_data;
    logic            wr_req, wr_rdy;
    logic [31:0]     wr_addr;
    logic [3:0]      wr_wstrb;
    logic [255:0]    wr_data;
    logic [ID_W-1:0] arid, rid, awid, bid;
    logic [31:0]     araddr, rdata, awaddr, wdata;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, awsize;
    logic [1:0]      arburst, rresp, awburst, bresp;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]      wstrb;

    dcache_axi_master #(.ID_W(ID_W), .RD_ID(1), .WR_ID(1)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
        .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic [2:0]  t;
        logic [31:0] addr;
        int          nb;
        logic [31:0] base;
        logic [31:0] step;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        logic [2:0]  exp_size;
        int          stall;
    } rd_vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } wbeat_t;

    int           checks = 0;
    int           errors = 0;
    logic [255:0] rq[$];
    wbeat_t       wq[$];
    bit           b_done;
    rd_vec_t      vecs[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Returned lines are checked against the expectation queue in arrival order.
    always @(negedge clk) begin
        if (ret_valid) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ret_unexpected: got ret_valid=1 expected no pending read");
            end else begin
                chk("ret_data", ret_data, rq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset && wvalid && wready) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w_unexpected: got wdata=%0h expected no beat", wdata);
            end else begin
                wbeat_t e;
                e = wq.pop_front();
                chk("wdata", {224'd0, wdata}, {224'd0, e.data});
                chk("wstrb", {252'd0, wstrb}, {252'd0, e.strb});
                chk("wlast", {255'd0, wlast}, {255'd0, e.last});
            end
        end
    end

    task automatic set_rd(input logic [2:0] t, input logic [31:0] a);
        rd_req = 1'b1; rd_type = t; rd_addr = a;
    endtask

    task automatic set_wr(input logic [31:0] a, input logic [31:0] base);
        wbeat_t e;
        wr_req = 1'b1; wr_addr = a; wr_wstrb = 4'hF;
        for (int i = 0; i < 8; i++) begin
            wr_data[i*32 +: 32] = base + 32'(i);
            e.data = base + 32'(i);
            e.strb = 4'hF;
            e.last = (i == 7);
            wq.push_back(e);
        end
    endtask

    // hz: -1 no hazard check, 0 AR must appear before write completes, 1 after
    task automatic rd_finish(input rd_vec_t v, input int hz);
        int c;
        logic [255:0] exp;
        c = 0;
        @(negedge clk);
        while (!arvalid && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (!arvalid) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout: got arvalid=0 expected 1 within 300 cycles");
            return;
        end
        if (hz >= 0) chk("hazard_order", {255'd0, b_done}, 256'(hz));
        chk("araddr", {224'd0, araddr}, {224'd0, v.exp_addr});
        chk("arlen", {248'd0, arlen}, {248'd0, v.exp_len});
        chk("arsize_burst", {251'd0, arsize, arburst}, {251'd0, v.exp_size, 2'b01});
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("ar_stall", {213'd0, arvalid, rd_rdy, arlen, araddr},
                {213'd0, 1'b1, 1'b0, v.exp_len, v.exp_addr});
        end
        @(posedge clk); #1 arready = 1'b1;
        @(posedge clk); #1 arready = 1'b0;
        exp = '0;
        for (int i = 0; i < v.nb && i < 8; i++) exp[i*32 +: 32] = v.base + 32'(i) * v.step;
        rq.push_back(exp);
        for (int i = 0; i < v.nb; i++) begin
            rvalid = 1'b1;
            rdata  = v.base + 32'(i) * v.step;
            rlast  = (i == v.nb - 1);
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        chk("ret_timing", {255'd0, ret_valid}, 256'd1);
        @(negedge clk);
        chk("ret_pulse_rdy", {254'd0, ret_valid, rd_rdy}, 256'd1);
        chk("rq_drained", 256'(rq.size()), 256'd0);
    endtask

    task automatic do_read(input rd_vec_t v);
        @(posedge clk); #1 set_rd(v.t, v.addr);
        @(posedge clk); #1 rd_req = 1'b0;
        rd_finish(v, -1);
    endtask

    task automatic wr_slave(input bit toggle, input logic [31:0] exp_aw);
        int c;
        int n;
        c = 0;
        wready = 1'b0;
        @(negedge clk);
        while (!awvalid && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (!awvalid) begin
            checks++;
            errors++;
            $display("FAIL aw_timeout: got awvalid=0 expected 1 within 100 cycles");
            return;
        end
        chk("awaddr", {224'd0, awaddr}, {224'd0, exp_aw});
        chk("aw_len_size_burst", {243'd0, awlen, awsize, awburst}, {243'd0, 8'd7, 3'd2, 2'b01});
        chk("wr_rdy_busy", {255'd0, wr_rdy}, 256'd0);
        @(posedge clk); #1 awready = 1'b1;
        @(posedge clk); #1 awready = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && n < 8; k++) begin
            wready = toggle ? ~wready : 1'b1;
            @(negedge clk);
            if (wvalid && wready) n++;
            if (n < 8) begin
                @(posedge clk); #1;
            end
        end
        if (n < 8) begin
            wready = 1'b0;
            checks++;
            errors++;
            $display("FAIL w_timeout: got %0d beats expected 8", n);
            return;
        end
        @(posedge clk); #1 wready = 1'b0; bvalid = 1'b1;
        @(negedge clk);
        chk("bready_wvalid", {254'd0, bready, wvalid}, 256'd2);
        @(posedge clk); #1 bvalid = 1'b0; b_done = 1'b1;
        @(negedge clk);
        chk("wr_rdy_after_b", {255'd0, wr_rdy}, 256'd1);
    endtask

    initial begin
        rd_vec_t hv;
        int c;
        vecs[0] = '{3'b100, 32'h1C000024, 8, 32'h11, 32'h11, 32'h1C000020, 8'd7, 3'd2, 0};
        vecs[1] = '{3'b010, 32'h1FD00004, 1, 32'hDEADBEEF, 32'h0, 32'h1FD00004, 8'd0, 3'd2, 0};
        vecs[2] = '{3'b001, 32'h12345672, 1, 32'h0000BEEF, 32'h0, 32'h12345672, 8'd0, 3'd1, 0};
        vecs[3] = '{3'b000, 32'h80000003, 1, 32'h000000A5, 32'h0, 32'h80000003, 8'd0, 3'd0, 0};
        vecs[4] = '{3'b011, 32'h00000010, 1, 32'h13572468, 32'h0, 32'h00000010, 8'd0, 3'd2, 0};
        vecs[5] = '{3'b100, 32'h0000003F, 8, 32'h01010101, 32'h01010101, 32'h00000020, 8'd7, 3'd2, 5};
        vecs[6] = '{3'b100, 32'h00400000, 3, 32'hCAFE0000, 32'h1, 32'h00400000, 8'd7, 3'd2, 0};
        vecs[7] = '{3'b100, 32'h00500044, 10, 32'h5000, 32'h100, 32'h00500040, 8'd7, 3'd2, 0};

        reset = 1'b0;
        rd_req = 0; rd_type = 0; rd_addr = 0;
        wr_req = 0; wr_addr = 0; wr_wstrb = 0; wr_data = '0;
        arready = 0; rid = 4'd1; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
        b_done = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valids", {249'd0, rd_rdy, wr_rdy, arvalid, rready, awvalid, wvalid, bready},
            {249'd0, 7'b1100000});
        chk("reset_ret", {255'd0, ret_valid}, 256'd0);
        chk("reset_ret_data", ret_data, 256'd0);
        @(posedge clk); #1 reset = 1'b1;

        for (int i = 0; i < 8; i++) do_read(vecs[i]);

        // writeback with wready toggling every other cycle
        b_done = 0;
        @(posedge clk); #1 set_wr(32'h00001040, 32'hA0);
        @(posedge clk); #1 wr_req = 1'b0;
        wr_slave(1'b1, 32'h00001040);

        // same-line read and write accepted together: AR only after B
        b_done = 0;
        hv = '{3'b100, 32'h00001048, 8, 32'h7000, 32'h1, 32'h00001040, 8'd7, 3'd2, 0};
        @(posedge clk); #1 set_wr(32'h00001040, 32'hB0); set_rd(hv.t, hv.addr);
        @(posedge clk); #1 wr_req = 1'b0; rd_req = 1'b0;
        fork
            wr_slave(1'b0, 32'h00001040);
            rd_finish(hv, 1);
        join

        // different line: AR proceeds alongside the write traffic
        b_done = 0;
        hv = '{3'b100, 32'h00002000, 8, 32'h9000, 32'h3, 32'h00002000, 8'd7, 3'd2, 0};
        @(posedge clk); #1 set_wr(32'h0000105C, 32'hC0); set_rd(hv.t, hv.addr);
        @(posedge clk); #1 wr_req = 1'b0; rd_req = 1'b0;
        fork
            wr_slave(1'b1, 32'h00001040);
            rd_finish(hv, 0);
        join

        // reset during beat 3 of a line read
        @(posedge clk); #1 set_rd(3'b100, 32'h00003000);
        @(posedge clk); #1 rd_req = 1'b0;
        c = 0;
        while (!arvalid && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rst_ar_seen", {255'd0, arvalid}, 256'd1);
        arready = 1'b1;
        @(posedge clk); #1 arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1; rdata = 32'(i + 1); rlast = 1'b0;
            @(posedge clk); #1;
        end
        rdata = 32'h4;
        #2 reset = 1'b0;
        #1;
        chk("rst_abort", {252'd0, rready, arvalid, rd_rdy, ret_valid}, {252'd0, 4'b0010});
        chk("rst_ret_data", ret_data, 256'd0);
        rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_ret", {255'd0, ret_valid}, 256'd0);
        end
        @(posedge clk); #1 reset = 1'b1;
        do_read(vecs[0]);

        repeat (3) @(posedge clk);
        chk("queues_empty", 256'(rq.size() + wq.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_axi_master.md
Name: dcache_axi_master

Overview:
- AXI4 master behind the data cache. Converts the cache's line-refill requests (rd_req/rd_type/rd_addr) into AXI read bursts and dirty-line writebacks (wr_req/wr_addr/wr_data) into AXI write bursts.
- Assembles read beats into a 256-bit ret_data line and returns it with a one-cycle ret_valid.
- Independent read and write channel FSMs. Reads are ordered behind writes to the same line.

Parameters:
- ID_W, 4, AXI ID width.
- RD_ID, 1, constant arid for all reads.
- WR_ID, 1, constant awid for all writes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request from cache.
- rd_type  in  3  000 byte, 001 half, 010 word, 100 line.
- rd_addr  in  32  physical read address.
- rd_rdy  out  1  read request accepted this cycle when high with rd_req.
- ret_valid  out  1  one-cycle pulse, ret_data valid.
- ret_data  out  256  returned data; beat i in bits [32i+31:32i].
- wr_req  in  1  writeback request, held until wr_rdy.
- wr_addr  in  32  physical line address.
- wr_wstrb  in  4  byte strobe applied to every beat.
- wr_data  in  256  line data, word i = bits [32i+31:32i].
- wr_rdy  out  1  write request accepted this cycle when high with wr_req.
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/32/8/3/2/1  AXI AR channel.
- arready  in  1.
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1.
- rready  out  1.
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/32/8/3/2/1  AXI AW channel.
- awready  in  1.
- wdata/wstrb/wlast/wvalid  out  32/4/1/1.
- wready  in  1.
- bid/bresp/bvalid  in  ID_W/2/1.
- bready  out  1.

Behaviour:
- Reset (reset=0, asynchronous): both FSMs go to IDLE.
  - All valid/ready outputs are 0, except rd_rdy=1 and wr_rdy=1.
  - ret_data=0, line buffers=0, beat counters=0.
  - Reset mid-burst abandons the transaction with no completion pulse.
- Read FSM states: R_IDLE, R_AR, R_DATA, R_RET.
- R_IDLE: rd_rdy=1.
  - rd_req=1 latches the request and goes to R_AR. The read buffer clears to 0.
  - rd_type=100: araddr={rd_addr[31:5],5'b0}, arlen=7, arsize=2, arburst=01 (INCR).
  - Other types: araddr=rd_addr, arlen=0, arburst=01, arsize=0/1/2 for byte/half/word.
  - Reserved rd_type is treated as word.
- R_AR: arvalid=1, held stable until arready. On arready, go to R_DATA.
  - Hazard: arvalid is held 0 while the write FSM is not in W_IDLE and the latched write line address [31:5] equals the read address [31:5].
- R_DATA: rready=1.
  - Each rvalid beat writes rdata into buffer word[cnt], then cnt increments.
  - rlast goes to R_RET. Words not received stay 0. Beats beyond 8 are dropped.
  - rresp is ignored; rid is not checked.
- R_RET: ret_valid=1 for exactly one cycle with ret_data=buffer, then R_IDLE.
  - Minimum latency: rd_req accept to ret_valid = 1 (AR) + N beats + 1 cycle.
- Write FSM states: W_IDLE, W_AW, W_DATA, W_RESP.
- W_IDLE: wr_rdy=1.
  - wr_req=1 latches {wr_addr[31:5],5'b0}, wr_wstrb and wr_data, then goes to W_AW.
- W_AW: awvalid=1, awlen=7, awsize=2, awburst=01. On awready, go to W_DATA.
- W_DATA: wvalid=1, wdata=word[cnt], wstrb=latched strobe, wlast=(cnt==7).
  - cnt increments on wready.
  - Handshake with cnt==7 goes to W_RESP.
- W_RESP: bready=1. bvalid returns to W_IDLE; bresp is ignored.
- Simultaneous rd_req and wr_req accepted in the same cycle: the hazard check compares against the write being latched that cycle, so a same-line read waits for bvalid.
- Read and write FSMs otherwise proceed concurrently.
- AXI stability: addr/len/size/valid and wdata/wstrb/wlast hold constant while valid=1 and ready=0.

Test Plan:
- Line read at 0x1C000024 → araddr=0x1C000020, arlen=7, arsize=2. Beats 0x11..0x88 give ret_data word0=0x11 … word7=0x88, with a single ret_valid pulse the cycle after rlast.
- Word read (rd_type=010) at 0x1FD00004 with one beat 0xDEADBEEF → arlen=0, araddr=0x1FD00004, ret_data[31:0]=0xDEADBEEF, bits [255:32]=0.
- Writeback at 0x00001040 with words 0..7=0xA0..0xA7, wready toggling every other cycle → 8 W beats in order, wlast only on 0xA7, wstrb=1111, bready high after the last beat, wr_rdy=1 again after bvalid.
- Write then read to the same line 0x00001040 accepted in the same cycle → arvalid stays 0 until bvalid; then AR issues.
  - Read to a different line 0x00002000 instead → AR issues in parallel with the AW/W traffic.
- arready held 0 for 5 cycles → araddr/arlen stable, arvalid remains 1, rd_rdy=0 throughout.
- reset asserted during beat 3 of a read burst → rready/arvalid drop immediately, no ret_valid, rd_rdy=1. A fresh request after release completes normally.
